// File: rtl/layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// layer_sequencer_if
// Bundles the configuration, run-control and compute-controller handshake
// signals of layer_sequencer.
//   master : host / compute-controller side (drives cfg, start, abort, done_*)
//   slave  : the sequencer itself
// Signals:
//   cfg_we, cfg_addr, cfg_type   layer-type table write port
//   num_layers, ping_init        sequence setup, sampled on start
//   start, abort                 run control
//   done_conv/dense/pool         one-cycle completion from compute controllers
//   comp_sel, ping               buffer/PE mux select
//   start_conv/dense/pool        one-cycle start to compute controllers
//   layer_idx, busy, seq_done, error   status
// ---------------------------------------------------------------------------
interface layer_sequencer_if #(
    parameter int LAYER_W = 4
);
    logic               cfg_we;
    logic [LAYER_W-1:0] cfg_addr;
    logic [1:0]         cfg_type;
    logic [LAYER_W:0]   num_layers;
    logic               ping_init;
    logic               start;
    logic               abort;
    logic               done_conv;
    logic               done_dense;
    logic               done_pool;
    logic [2:0]         comp_sel;
    logic               ping;
    logic               start_conv;
    logic               start_dense;
    logic               start_pool;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               seq_done;
    logic               error;

    modport master (
        output cfg_we, cfg_addr, cfg_type, num_layers, ping_init, start, abort,
               done_conv, done_dense, done_pool,
        input  comp_sel, ping, start_conv, start_dense, start_pool,
               layer_idx, busy, seq_done, error
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_type, num_layers, ping_init, start, abort,
               done_conv, done_dense, done_pool,
        output comp_sel, ping, start_conv, start_dense, start_pool,
               layer_idx, busy, seq_done, error
    );
endinterface

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Walks a network layer by layer: reads the layer type from a small table,
// starts the matching conv/dense/pool controller, waits for its done, then
// flips the BUF1/BUF2 ping-pong so each layer's output feeds the next layer.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active high
//   bus   layer_sequencer_if.slave (config, run control, compute handshake,
//         comp_sel/ping mux selects, status)
//
// state  | meaning
// IDLE   | waiting for start; table writable
// LOAD   | read layer type for layer_idx; illegal type aborts with error
// ISSUE  | drive comp_sel and one-cycle start_* to the selected controller
// RUN    | wait for the issued controller's done; watchdog running
// SWITCH | comp_sel quiet gap; advance layer, flip ping
// FINISH | one-cycle seq_done
// ---------------------------------------------------------------------------
module layer_sequencer #(
    parameter int N_LAYER_MAX = 16,
    parameter int LAYER_W     = $clog2(N_LAYER_MAX),
    parameter int TIMEOUT_W   = 20
) (
    input logic              clk,
    input logic              rst,
    layer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_RUN, S_SWITCH, S_FINISH
    } state_t;

    localparam logic [1:0] T_CONV  = 2'b01;
    localparam logic [1:0] T_DENSE = 2'b10;
    localparam logic [1:0] T_POOL  = 2'b11;

    localparam logic [LAYER_W:0] NUM_MAX = (LAYER_W+1)'(N_LAYER_MAX);
    // Down-counter reaches zero on the (2**TIMEOUT_W-1)-th RUN cycle.
    localparam logic [TIMEOUT_W-1:0] WDOG_LOAD = TIMEOUT_W'((2**TIMEOUT_W) - 2);

    state_t               state, state_next;
    logic [1:0]           type_tbl [N_LAYER_MAX];
    logic [1:0]           tbl_rd;
    logic [1:0]           type_q;
    logic [LAYER_W-1:0]   layer_idx_q;
    logic [LAYER_W:0]     num_q;
    logic [LAYER_W:0]     num_eff;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 ping_q;
    logic                 error_q;
    logic                 done_hit;
    logic                 wdog_tc;
    logic                 last_layer;
    logic                 start_ok;

    logic [2:0]           comp_sel_c;
    logic                 start_conv_c, start_dense_c, start_pool_c;
    logic                 busy_c, seq_done_c;

    assign num_eff    = (bus.num_layers > NUM_MAX) ? NUM_MAX : bus.num_layers;
    assign tbl_rd     = type_tbl[layer_idx_q];
    assign wdog_tc    = (wdog == '0);
    assign last_layer = (({1'b0, layer_idx_q} + (LAYER_W+1)'(1)) == num_q);
    assign start_ok   = bus.start && !bus.abort;
    // Only the controller that was issued may end the RUN phase.
    assign done_hit   = ((type_q == T_CONV)  && bus.done_conv)  ||
                        ((type_q == T_DENSE) && bus.done_dense) ||
                        ((type_q == T_POOL)  && bus.done_pool);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        comp_sel_c    = 3'b000;
        start_conv_c  = 1'b0;
        start_dense_c = 1'b0;
        start_pool_c  = 1'b0;
        busy_c        = 1'b1;
        seq_done_c    = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (start_ok) begin
                    state_next = (num_eff == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort || (tbl_rd == 2'b00)) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                comp_sel_c    = {1'b0, type_q};
                start_conv_c  = (type_q == T_CONV);
                start_dense_c = (type_q == T_DENSE);
                start_pool_c  = (type_q == T_POOL);
                state_next    = bus.abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                comp_sel_c = {1'b0, type_q};
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (done_hit) begin
                    state_next = S_SWITCH;
                end else if (wdog_tc) begin
                    state_next = S_IDLE;
                end
            end
            S_SWITCH: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = last_layer ? S_FINISH : S_LOAD;
                end
            end
            S_FINISH: begin
                seq_done_c = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_idx_q <= '0;
            num_q       <= '0;
            ping_q      <= 1'b1;
            error_q     <= 1'b0;
            type_q      <= 2'b00;
            wdog        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        num_q       <= num_eff;
                        ping_q      <= bus.ping_init;
                        error_q     <= 1'b0;
                        layer_idx_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (!bus.abort) begin
                        type_q <= tbl_rd;
                        if (tbl_rd == 2'b00) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    wdog <= WDOG_LOAD;
                end
                S_RUN: begin
                    if (!bus.abort && !done_hit) begin
                        if (wdog_tc) begin
                            error_q <= 1'b1;
                        end else begin
                            wdog <= wdog - TIMEOUT_W'(1);
                        end
                    end
                end
                S_SWITCH: begin
                    if (!bus.abort) begin
                        ping_q      <= ~ping_q;
                        layer_idx_q <= layer_idx_q + LAYER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Table contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && (state == S_IDLE)) begin
            type_tbl[bus.cfg_addr] <= bus.cfg_type;
        end
    end

    assign bus.comp_sel    = comp_sel_c;
    assign bus.start_conv  = start_conv_c;
    assign bus.start_dense = start_dense_c;
    assign bus.start_pool  = start_pool_c;
    assign bus.busy        = busy_c;
    assign bus.seq_done    = seq_done_c;
    assign bus.ping        = ping_q;
    assign bus.error       = error_q;
    assign bus.layer_idx   = layer_idx_q;

endmodule
